// File: rtl/led_trail_dimmer_pkg.sv
// Shared constants for the LED light chain (running-light stage and trail dimmer).
// Also holds the per-channel level update rule.
package led_trail_dimmer_pkg;

    localparam int N_LED     = 16;
    localparam int PWM_BITS  = 4;
    localparam int LEVEL_MAX = (1 << PWM_BITS) - 1;
    localparam int DECAY_DIV = 10;

    typedef enum logic [1:0] {
        LVL_HOLD,
        LVL_LOAD,
        LVL_DECAY
    } lvl_op_e;

    // A fresh hit from the running light always beats a decay step on the same edge.
    function automatic lvl_op_e lvl_op(input logic load, input logic tick);
        if (load) return LVL_LOAD;
        if (tick) return LVL_DECAY;
        return LVL_HOLD;
    endfunction

endpackage

// File: rtl/led_fade_ch.sv
// One trail channel: brightness level with load/decay and a registered PWM compare.
module led_fade_ch #(
    parameter int PWM_BITS = led_trail_dimmer_pkg::PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out
);
    import led_trail_dimmer_pkg::*;

    logic [PWM_BITS-1:0] level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level   <= '0;
            led_out <= 1'b0;
        end else begin
            // Compare uses the pre-edge level, so a fresh load shows up one edge later.
            led_out <= en && (level > pwm_cnt);
            if (en) begin
                case (lvl_op(load, decay_tick))
                    LVL_LOAD:  level <= '1;
                    LVL_DECAY: level <= (level == '0) ? level : level - 1'b1;
                    default:   level <= level;
                endcase
            end
        end
    end

endmodule

// File: rtl/led_trail_dimmer.sv
// Turns a one-hot running light into a fading trail: shared PWM and decay
// counters drive N_LED independent fade channels.
module led_trail_dimmer #(
    parameter int N_LED     = led_trail_dimmer_pkg::N_LED,
    parameter int PWM_BITS  = led_trail_dimmer_pkg::PWM_BITS,
    parameter int DECAY_DIV = led_trail_dimmer_pkg::DECAY_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_LED-1:0] led_in,
    output logic [N_LED-1:0] led_out,
    output logic             pwm_sync
);
    localparam int DW       = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int PWM_LAST = (1 << PWM_BITS) - 2;
    localparam int DEC_LAST = DECAY_DIV - 1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DW-1:0]       dcnt;
    logic                decay_tick;

    assign decay_tick = en && (dcnt == DW'(DEC_LAST));

    // PWM period is LEVEL_MAX cycles so level LEVEL_MAX means always on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt  <= '0;
            dcnt     <= '0;
            pwm_sync <= 1'b0;
        end else begin
            pwm_sync <= en && (pwm_cnt == '0);
            if (en) begin
                pwm_cnt <= (pwm_cnt == PWM_BITS'(PWM_LAST)) ? '0 : pwm_cnt + 1'b1;
                dcnt    <= decay_tick ? '0 : dcnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        led_fade_ch #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .load       (led_in[i]),
            .decay_tick (decay_tick),
            .pwm_cnt    (pwm_cnt),
            .led_out    (led_out[i])
        );
    end

endmodule

// File: tb/tb_led_trail_dimmer.sv
// Directed bench for led_trail_dimmer: reset, full brightness, trail decay,
// load/decay collision, freeze, running pattern with wrap, mid-run reset.
module tb_led_trail_dimmer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] led_in = '0;
    logic [15:0] led_out;
    logic        pwm_sync;

    logic [3:0] lv0, lv3, lv13, lv14, lv15;

    int n;       // enabled edges since reset release
    int total;
    int passes;
    int highs;

    led_trail_dimmer u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .led_in   (led_in),
        .led_out  (led_out),
        .pwm_sync (pwm_sync)
    );

    assign lv0  = u_dut.g_ch[0].u_ch.level;
    assign lv3  = u_dut.g_ch[3].u_ch.level;
    assign lv13 = u_dut.g_ch[13].u_ch.level;
    assign lv14 = u_dut.g_ch[14].u_ch.level;
    assign lv15 = u_dut.g_ch[15].u_ch.level;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s at n=%0d: got %0h expected %0h", tag, n, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && en) n++;
        #1;
    endtask

    // Level after enabled edge x for a channel last loaded on tick edge t0.
    function automatic int lvl_trail(input int x, input int t0);
        int t;
        t = (x - t0) / 10;
        return (t >= 15) ? 0 : 15 - t;
    endfunction

    function automatic logic [31:0] sync_exp(input int e);
        return ((e - 1) % 15 == 0) ? 32'd1 : 32'd0;
    endfunction

    // Running pattern: segment k covers edges 381+10k .. 390+10k, lead bit k%16.
    function automatic logic [15:0] pat_in(input int x);
        logic [15:0] one;
        one = 16'h0001;
        return one << (((x - 381) / 10) % 16);
    endfunction

    function automatic int pat_lvl(input int c, input int x);
        int k, kl, t;
        k = (x < 381) ? -1 : (x - 381) / 10;
        if (k >= c) begin
            kl = k - ((k - c) % 16);
            if (kl == k) return 15;
            t = (x - (390 + 10 * kl)) / 10;
            return (t >= 15) ? 0 : 15 - t;
        end
        if (c == 3) return lvl_trail(x, 300);
        return 0;
    endfunction

    initial begin
        logic [15:0] ev;
        n = 0; total = 0; passes = 0; highs = 0;

        // Reset asserted between edges with garbage inputs
        #2 rst = 1'b0;
        en = 1'b1;
        led_in = 16'($urandom);
        #1;
        chk("rst_led_out", led_out, 0);
        chk("rst_sync", pwm_sync, 0);
        chk("rst_lv0", lv0, 0);
        repeat (3) begin
            tick();
            led_in = 16'($urandom);
            en = 1'($urandom_range(0, 1));
            chk("rst_hold_out", led_out, 0);
            chk("rst_hold_sync", pwm_sync, 0);
        end
        rst = 1'b1;
        en = 1'b1;
        led_in = 16'h0001;

        // Full brightness on channel 0
        while (n < 30) begin
            tick();
            chk("full_out", led_out, (n >= 2) ? 32'd1 : 32'd0);
            chk("full_sync", pwm_sync, sync_exp(n));
        end
        chk("full_lv0", lv0, 15);

        // Trail on channel 0, last load on tick edge 30
        led_in = '0;
        while (n < 189) begin
            tick();
            chk("trail_out", led_out, (lvl_trail(n - 1, 30) > (n - 1) % 15) ? 32'd1 : 32'd0);
            chk("trail_sync", pwm_sync, sync_exp(n));
            if (n == 179) chk("trail_lv0_179", lv0, 1);
            if (n == 180) chk("trail_lv0_180", lv0, 0);
        end

        // Channel 3 loaded on tick edge 190, then decays to 5
        led_in = 16'h0008;
        tick();
        led_in = '0;
        chk("ch3_load_out", led_out, 0);
        chk("ch3_load_lv", lv3, 15);
        while (n < 299) begin
            tick();
            chk("ch3_out", led_out,
                (lvl_trail(n - 1, 190) > (n - 1) % 15) ? 32'h8 : 32'h0);
        end
        chk("ch3_pre_coll", lv3, 5);

        // Load coincides with decay tick at edge 300
        led_in = 16'h0008;
        tick();
        led_in = '0;
        chk("collision_lv3", lv3, 15);
        chk("collision_out", led_out, 0);
        while (n < 365) begin
            tick();
            chk("ch3b_out", led_out,
                (lvl_trail(n - 1, 300) > (n - 1) % 15) ? 32'h8 : 32'h0);
        end
        chk("freeze_pre_lv3", lv3, 9);

        // Freeze mid-period: counters at pwm 5, decay 5
        en = 1'b0;
        led_in = 16'hFFFF;
        repeat (37) begin
            tick();
            chk("freeze_out", led_out, 0);
            chk("freeze_sync", pwm_sync, 0);
        end
        chk("freeze_lv3", lv3, 9);

        en = 1'b1;
        led_in = '0;
        while (n < 380) begin
            tick();
            chk("resume_out", led_out,
                (lvl_trail(n - 1, 300) > (n - 1) % 15) ? 32'h8 : 32'h0);
            chk("resume_sync", pwm_sync, sync_exp(n));
            highs += int'(led_out[3]);
        end
        chk("resume_duty", highs, 9);

        // Running pattern, rotating every 10 edges through the 15->0 wrap
        while (n < 580) begin
            led_in = pat_in(n + 1);
            tick();
            ev = '0;
            for (int c = 0; c < 16; c++)
                ev[c] = (pat_lvl(c, n - 1) > (n - 1) % 15);
            chk("pattern_out", led_out, ev);
            if (n == 550) begin
                chk("wrap_lead0", lv0, 15);
                chk("wrap_lv15", lv15, 14);
                chk("wrap_lv14", lv14, 13);
                chk("wrap_lv13", lv13, 12);
            end
        end

        // Reset mid-run discards the trail; counters restart from 0
        #3 rst = 1'b0;
        #1;
        chk("midrst_out", led_out, 0);
        chk("midrst_sync", pwm_sync, 0);
        chk("midrst_lv0", lv0, 0);
        chk("midrst_lv15", lv15, 0);
        tick();
        rst = 1'b1;
        n = 0;
        en = 1'b1;
        led_in = 16'h0001;
        while (n < 16) begin
            tick();
            chk("restart_out", led_out, (n >= 2) ? 32'd1 : 32'd0);
            chk("restart_sync", pwm_sync, sync_exp(n));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
